// File: rtl/pc_pkg.sv
// -----------------------------------------------------------------------------
// pc_pkg
// Shared definitions for the program-counter sequencer:
//   - state_e      : sequencer FSM states
//   - PC_SEL_*     : one-hot next-PC select codes for the PC input mux
//   - OPC_*        : opcodes the sequencer handles itself
//   - CALL_*       : op sub-field values for the OPC_CALL group
//   - COND_*       : branch condition codes
// -----------------------------------------------------------------------------
package pc_pkg;

    typedef enum logic [2:0] {
        S_RESET,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_UPDATE,
        S_HALT
    } state_e;

    // One-hot select for the PC input mux.
    localparam logic [3:0] PC_SEL_RD   = 4'b1000;  // Rd value (BX/BLX)
    localparam logic [3:0] PC_SEL_BR   = 4'b0100;  // pc + 1 + sx(im8)
    localparam logic [3:0] PC_SEL_ZERO = 4'b0010;  // reset vector
    localparam logic [3:0] PC_SEL_SEQ  = 4'b0001;  // pc + 1

    localparam logic [2:0] OPC_BRANCH = 3'b001;
    localparam logic [2:0] OPC_CALL   = 3'b010;
    localparam logic [2:0] OPC_HALT   = 3'b111;

    // op sub-field within the OPC_CALL group.
    localparam logic [1:0] CALL_BX  = 2'b00;
    localparam logic [1:0] CALL_NOP = 2'b01;  // behaves as a plain sequential step
    localparam logic [1:0] CALL_BLX = 2'b10;
    localparam logic [1:0] CALL_BL  = 2'b11;

    // Branch conditions; codes above COND_LE are never taken.
    localparam logic [2:0] COND_AL = 3'b000;  // always
    localparam logic [2:0] COND_EQ = 3'b001;  // Z
    localparam logic [2:0] COND_NE = 3'b010;  // !Z
    localparam logic [2:0] COND_LT = 3'b011;  // N ^ V
    localparam logic [2:0] COND_LE = 3'b100;  // (N ^ V) | Z

endpackage

// File: rtl/pc_sequencer_if.sv
// -----------------------------------------------------------------------------
// pc_sequencer_if
// Fetch handshake to instruction memory plus the decoded-instruction fields
// consumed by the sequencer.
//   fetch_req   : sequencer -> memory, read request at mem_addr
//   mem_addr    : sequencer -> memory, fetch address (K bits)
//   fetch_ack   : memory -> sequencer, instruction latched into IR
//   instr_valid : decoder -> sequencer, fields below are valid
//   opcode, op, cond, im8 : decoded instruction fields
//   rd_val      : Rd value for BX/BLX (K bits)
// Modports: master = sequencer side, slave = memory/decoder side.
// -----------------------------------------------------------------------------
interface pc_sequencer_if #(
    parameter int K = 9
);
    logic         fetch_req;
    logic         fetch_ack;
    logic [K-1:0] mem_addr;
    logic         instr_valid;
    logic [2:0]   opcode;
    logic [1:0]   op;
    logic [2:0]   cond;
    logic [7:0]   im8;
    logic [K-1:0] rd_val;

    modport master (
        output fetch_req, mem_addr,
        input  fetch_ack, instr_valid, opcode, op, cond, im8, rd_val
    );

    modport slave (
        input  fetch_req, mem_addr,
        output fetch_ack, instr_valid, opcode, op, cond, im8, rd_val
    );

endinterface

// File: rtl/branch_cond_eval.sv
// -----------------------------------------------------------------------------
// branch_cond_eval
// Purely combinational branch condition evaluator, kept separate so that
// future branch-prediction logic can share it.
//   cond    in  3  condition code
//   Z, N, V in  1  status flags
//   taken   out 1  branch condition holds
// -----------------------------------------------------------------------------
module branch_cond_eval
    import pc_pkg::*;
(
    input  logic [2:0] cond,
    input  logic       Z,
    input  logic       N,
    input  logic       V,
    output logic       taken
);

    always_comb begin
        // NOTE: default assignment first so every path drives taken; no latch.
        taken = 1'b0;
        case (cond)
            COND_AL: taken = 1'b1;
            COND_EQ: taken = Z;
            COND_NE: taken = ~Z;
            COND_LT: taken = N ^ V;
            COND_LE: taken = (N ^ V) | Z;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Owns the program counter and sequences fetch -> decode -> execute -> PC
// update for every instruction. Resolves conditional branches, BL/BX/BLX and
// HALT, and drives the one-hot next-PC select for the PC input mux.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   bus        if   pc_sequencer_if.master (fetch handshake + decoder fields)
//   Z, N, V    in   status flags, sampled when the instruction is dispatched
//   exec_done  in   datapath finished a non-branch instruction
//   resume     in   leave S_HALT (only with PC_HALT_RESUME_EN defined)
//   pc         out  current PC register (K bits)
//   pc_sel     out  one-hot next-PC select (PC_SEL_*)
//   load_pc    out  PC register load strobe
//   lr_wr      out  write lr_data to R7
//   lr_data    out  link value, pc + 1
//   halted     out  high while in S_HALT
//
// Optional build macro: PC_HALT_RESUME_EN adds the resume input. Without it
// S_HALT is terminal until reset.
// -----------------------------------------------------------------------------
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int K = 9
) (
    input  logic          clk,
    input  logic          reset,
    pc_sequencer_if.master bus,
    input  logic          Z,
    input  logic          N,
    input  logic          V,
    input  logic          exec_done,
`ifdef PC_HALT_RESUME_EN
    input  logic          resume,
`endif
    output logic [K-1:0]  pc,
    output logic [3:0]    pc_sel,
    output logic          load_pc,
    output logic          lr_wr,
    output logic [K-1:0]  lr_data,
    output logic          halted
);

    state_e       state;
    logic         fetch_req_q;
    logic [K-1:0] next_pc;     // value pc takes in S_UPDATE, captured on entry

    logic [K-1:0] seq_pc;
    logic [K-1:0] br_pc;
    logic         taken;
    logic [3:0]   dec_sel;
    logic         dec_lr;
    logic [K-1:0] dec_target;

    // Width cast of the signed offset sign-extends im8 to K bits; the sum
    // wraps modulo 2^K naturally.
    assign seq_pc  = pc + K'(1);
    assign br_pc   = seq_pc + K'($signed(bus.im8));
    assign lr_data = seq_pc;

    assign bus.fetch_req = fetch_req_q;
    assign bus.mem_addr  = pc;

    branch_cond_eval u_cond (
        .cond  (bus.cond),
        .Z     (Z),
        .N     (N),
        .V     (V),
        .taken (taken)
    );

    // Select and link decision for an instruction leaving S_DECODE. Target
    // and flags are captured at dispatch, so later input changes cannot
    // disturb the update.
    always_comb begin
        dec_sel = PC_SEL_SEQ;
        dec_lr  = 1'b0;
        if (bus.opcode == OPC_BRANCH) begin
            dec_sel = taken ? PC_SEL_BR : PC_SEL_SEQ;
        end else if (bus.opcode == OPC_CALL) begin
            case (bus.op)
                CALL_BL: begin
                    dec_sel = PC_SEL_BR;
                    dec_lr  = 1'b1;
                end
                CALL_BX:  dec_sel = PC_SEL_RD;
                CALL_BLX: begin
                    dec_sel = PC_SEL_RD;
                    dec_lr  = 1'b1;
                end
                default:  dec_sel = PC_SEL_SEQ;
            endcase
        end
    end

    always_comb begin
        case (dec_sel)
            PC_SEL_RD: dec_target = bus.rd_val;
            PC_SEL_BR: dec_target = br_pc;
            default:   dec_target = seq_pc;
        endcase
    end

    // Single-process FSM with registered outputs: each output register is
    // loaded with the value belonging to the state being entered, so outputs
    // line up with the state without a combinational decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: synchronous reset clears every register, including
            // next_pc, so the bench never sees X on any output.
            state       <= S_RESET;
            pc          <= '0;
            next_pc     <= '0;
            fetch_req_q <= 1'b0;
            pc_sel      <= PC_SEL_ZERO;
            load_pc     <= 1'b1;
            lr_wr       <= 1'b0;
            halted      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout; the defaults below
            // make the update strobes single-cycle pulses.
            pc_sel  <= 4'b0000;
            load_pc <= 1'b0;
            lr_wr   <= 1'b0;

            case (state)
                S_RESET: begin
                    pc          <= '0;
                    fetch_req_q <= 1'b1;
                    state       <= S_FETCH;
                end

                S_FETCH: begin
                    if (bus.fetch_ack) begin
                        fetch_req_q <= 1'b0;
                        state       <= S_DECODE;
                    end
                end

                S_DECODE: begin
                    if (bus.instr_valid) begin
                        if (bus.opcode == OPC_HALT) begin
                            halted <= 1'b1;
                            state  <= S_HALT;
                        end else if (bus.opcode == OPC_BRANCH ||
                                     bus.opcode == OPC_CALL) begin
                            pc_sel  <= dec_sel;
                            load_pc <= 1'b1;
                            lr_wr   <= dec_lr;
                            next_pc <= dec_target;
                            state   <= S_UPDATE;
                        end else begin
                            state <= S_EXEC;
                        end
                    end
                end

                S_EXEC: begin
                    if (exec_done) begin
                        pc_sel  <= PC_SEL_SEQ;
                        load_pc <= 1'b1;
                        next_pc <= seq_pc;
                        state   <= S_UPDATE;
                    end
                end

                S_UPDATE: begin
                    pc          <= next_pc;
                    fetch_req_q <= 1'b1;
                    state       <= S_FETCH;
                end

                S_HALT: begin
`ifdef PC_HALT_RESUME_EN
                    if (resume) begin
                        halted  <= 1'b0;
                        pc_sel  <= PC_SEL_SEQ;
                        load_pc <= 1'b1;
                        next_pc <= seq_pc;
                        state   <= S_UPDATE;
                    end
`endif
                end

                default: begin
                    fetch_req_q <= 1'b0;
                    pc_sel      <= PC_SEL_ZERO;
                    load_pc     <= 1'b1;
                    halted      <= 1'b0;
                    pc          <= '0;
                    state       <= S_RESET;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
// Self-checking bench for pc_sequencer. The bench plays instruction memory,
// decoder and datapath; a reference model tracks the architectural PC with
// integer arithmetic and predicts select, link and next PC per instruction.
// Optional build macro: PC_HALT_RESUME_EN (adds the resume checks).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_pc_sequencer;

    localparam int K   = 9;
    localparam int MOD = 1 << K;

    logic         clk = 1'b0;
    logic         reset;
    logic         Z, N, V;
    logic         exec_done;
`ifdef PC_HALT_RESUME_EN
    logic         resume;
`endif
    logic [K-1:0] pc;
    logic [3:0]   pc_sel;
    logic         load_pc;
    logic         lr_wr;
    logic [K-1:0] lr_data;
    logic         halted;

    pc_sequencer_if #(.K(K)) bus ();

    pc_sequencer #(.K(K)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .Z         (Z),
        .N         (N),
        .V         (V),
        .exec_done (exec_done),
`ifdef PC_HALT_RESUME_EN
        .resume    (resume),
`endif
        .pc        (pc),
        .pc_sel    (pc_sel),
        .load_pc   (load_pc),
        .lr_wr     (lr_wr),
        .lr_data   (lr_data),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    int n_compared   = 0;
    int n_mismatched = 0;
    int model_pc     = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Architectural reference: what the next PC, select and link write must
    // be for one instruction, given the current model PC.
    function automatic void ref_model(input int opc, input int op, input int cnd,
                                      input int im, input int rd,
                                      input bit z, input bit n, input bit v,
                                      output logic [3:0] sel, output bit lr,
                                      output int nxt);
        bit taken;
        int simm;
        int seq;
        int br;
        simm = (im >= 128) ? im - 256 : im;
        seq  = (model_pc + 1) % MOD;
        br   = (model_pc + 1 + simm + MOD) % MOD;
        case (cnd)
            0:       taken = 1'b1;
            1:       taken = z;
            2:       taken = !z;
            3:       taken = (n != v);
            4:       taken = (n != v) || z;
            default: taken = 1'b0;
        endcase
        sel = 4'b0001;
        lr  = 1'b0;
        nxt = seq;
        if (opc == 1 && taken) begin
            sel = 4'b0100;
            nxt = br;
        end else if (opc == 2) begin
            if (op == 3) begin
                sel = 4'b0100; lr = 1'b1; nxt = br;
            end else if (op == 0) begin
                sel = 4'b1000; nxt = rd;
            end else if (op == 2) begin
                sel = 4'b1000; lr = 1'b1; nxt = rd;
            end
        end
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pc", pc, 0);
        check("rst_pc_sel", pc_sel, 4'b0010);
        check("rst_load_pc", load_pc, 1);
        check("rst_fetch_req", bus.fetch_req, 0);
        check("rst_halted", halted, 0);
        check("rst_lr_wr", lr_wr, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_fetch_req", bus.fetch_req, 1);
        check("post_rst_mem_addr", bus.mem_addr, 0);
        check("post_rst_pc_sel", pc_sel, 4'b0000);
        model_pc = 0;
    endtask

    // Carries one instruction from fetch through PC update. Called at
    // posedge+1 with the sequencer fetching (or about to).
    task automatic run_instr(input int opc, input int op, input int cnd,
                             input int im, input int rd,
                             input bit z, input bit n, input bit v,
                             input int ack_d, input int dec_d, input int exe_d);
        logic [3:0] e_sel;
        bit         e_lr;
        int         e_next;
        int         waited;
        waited = 0;
        while (bus.fetch_req !== 1'b1 && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("fetch_req", bus.fetch_req, 1);
        check("mem_addr", bus.mem_addr, model_pc);
        if (ack_d > 0) bus.fetch_ack = 1'b0;
        repeat (ack_d) begin
            @(posedge clk);
            #1;
            check("fetch_hold", bus.fetch_req, 1);
        end
        bus.fetch_ack = 1'b1;
        @(posedge clk);
        #1;
        bus.fetch_ack = 1'b0;
        check("fetch_drop", bus.fetch_req, 0);
        repeat (dec_d) begin
            @(posedge clk);
            #1;
        end
        bus.opcode      = opc[2:0];
        bus.op          = op[1:0];
        bus.cond        = cnd[2:0];
        bus.im8         = im[7:0];
        bus.rd_val      = rd[K-1:0];
        Z               = z;
        N               = n;
        V               = v;
        bus.instr_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        ref_model(opc, op, cnd, im, rd, z, n, v, e_sel, e_lr, e_next);
        if (opc == 7) begin
            check("halt_entry", halted, 1);
            return;
        end
        if (opc != 1 && opc != 2) begin
            repeat (exe_d) begin
                check("exec_no_load", load_pc, 0);
                @(posedge clk);
                #1;
            end
            exec_done = 1'b1;
            @(posedge clk);
            #1;
            exec_done = 1'b0;
        end
        check("upd_pc_sel", pc_sel, e_sel);
        check("upd_load_pc", load_pc, 1);
        check("upd_lr_wr", lr_wr, e_lr);
        if (e_lr) check("upd_lr_data", lr_data, (model_pc + 1) % MOD);
        check("upd_halted", halted, 0);
        @(posedge clk);
        #1;
        check("next_pc", pc, e_next);
        check("next_load_pc", load_pc, 0);
        model_pc = e_next;
    endtask

    task automatic jump_to(input int target);
        run_instr(2, 0, 0, 0, target, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset           = 1'b1;
        bus.fetch_ack   = 1'b0;
        bus.instr_valid = 1'b0;
        bus.opcode      = '0;
        bus.op          = '0;
        bus.cond        = '0;
        bus.im8         = '0;
        bus.rd_val      = '0;
        Z = 1'b0; N = 1'b0; V = 1'b0;
        exec_done       = 1'b0;
`ifdef PC_HALT_RESUME_EN
        resume          = 1'b0;
`endif

        // Reset with fetch_ack tied high.
        bus.fetch_ack = 1'b1;
        do_reset();

        // ALU instruction with a 3-cycle execute.
        jump_to(5);
        run_instr(5, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1, 1, 3);

        // BEQ -4, taken then not taken.
        jump_to(10);
        run_instr(1, 0, 1, 8'hFC, 0, 1'b1, 1'b0, 1'b0, 0, 0, 0);
        jump_to(10);
        run_instr(1, 0, 1, 8'hFC, 0, 1'b0, 1'b0, 1'b0, 0, 0, 0);

        // BL +5 then BX back to the link value.
        jump_to(20);
        run_instr(2, 3, 0, 8'h05, 0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        run_instr(2, 0, 0, 0, 21, 1'b0, 1'b0, 1'b0, 0, 0, 0);

        // Wraparound: sequential from the top, and a forward branch across it.
        jump_to(9'h1FF);
        run_instr(0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        jump_to(9'h1FE);
        run_instr(1, 0, 0, 8'h03, 0, 1'b0, 1'b0, 1'b0, 0, 0, 0);

        // Randomized instruction stream (everything except HALT).
        for (int i = 0; i < 150; i++) begin
            run_instr($urandom_range(0, 6), $urandom_range(0, 3),
                      $urandom_range(0, 7), $urandom_range(0, 255),
                      $urandom_range(0, MOD - 1),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)),
                      $urandom_range(0, 2), $urandom_range(0, 2),
                      $urandom_range(0, 3));
        end

        // HALT: pc frozen for 10 cycles while stray handshakes are ignored.
        jump_to(9'h040);
        run_instr(7, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        bus.fetch_ack   = 1'b1;
        bus.instr_valid = 1'b1;
        bus.opcode      = 3'b001;
        exec_done       = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("halt_pc", pc, model_pc);
            check("halt_flag", halted, 1);
            check("halt_fetch_req", bus.fetch_req, 0);
            check("halt_load_pc", load_pc, 0);
        end
        bus.fetch_ack   = 1'b0;
        bus.instr_valid = 1'b0;
        exec_done       = 1'b0;

`ifdef PC_HALT_RESUME_EN
        resume = 1'b1;
        @(posedge clk);
        #1;
        resume = 1'b0;
        check("resume_pc_sel", pc_sel, 4'b0001);
        check("resume_load_pc", load_pc, 1);
        check("resume_halted", halted, 0);
        @(posedge clk);
        #1;
        model_pc = (model_pc + 1) % MOD;
        check("resume_pc", pc, model_pc);
        check("resume_fetch_req", bus.fetch_req, 1);
        run_instr(4, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 1);
`endif

        // Leave HALT via reset, then reset in the middle of a fetch wait.
        do_reset();
        jump_to(9'h033);
        bus.fetch_ack = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("wait_fetch_req", bus.fetch_req, 1);
            check("wait_mem_addr", bus.mem_addr, 9'h033);
        end
        do_reset();
        run_instr(0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_compared, n_mismatched);
        $finish;
    end

endmodule
